// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//
// Purpose: bundles every hazard-detection input and every stall/flush output
// of the central pipeline hazard sequencer, so the controller and its
// surroundings connect through one port.
//
// Parameter:
//    CNT_W           width of the two performance counters
//
// Signals (pipeline -> controller):
//    id_rs1, id_rs2          source registers of the instruction in ID
//    id_uses_rs1/rs2         ID instruction actually reads rs1 / rs2
//    ex_rd, ex_MemRead       destination and load flag of the instruction in EX
//    ex_branch_taken         branch/jump in EX resolved taken
//    ex_md_start             EX holds a multi-cycle mul/div op
//    md_done                 mul/div result valid (one-cycle pulse)
//    mem_req, dmem_ready     MEM stage access and data memory completion
// Signals (controller -> pipeline):
//    pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
//    ex_mem_stall, ex_mem_flush    pipeline register controls
//    md_timeout                    sticky mul/div watchdog error
//    stall_cycles, flush_events    performance counters
//
// Modports: master = pipeline side, slave = hazard controller side.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic [4:0]       ex_rd;
   logic             ex_MemRead;
   logic             ex_branch_taken;
   logic             ex_md_start;
   logic             md_done;
   logic             mem_req;
   logic             dmem_ready;

   logic             pc_stall;
   logic             if_id_stall;
   logic             if_id_flush;
   logic             id_ex_stall;
   logic             id_ex_flush;
   logic             ex_mem_stall;
   logic             ex_mem_flush;
   logic             md_timeout;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_events;

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_MemRead,
             ex_branch_taken, ex_md_start, md_done, mem_req, dmem_ready,
      input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
             ex_mem_stall, ex_mem_flush, md_timeout, stall_cycles, flush_events
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_MemRead,
             ex_branch_taken, ex_md_start, md_done, mem_req, dmem_ready,
      output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
             ex_mem_stall, ex_mem_flush, md_timeout, stall_cycles, flush_events
   );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose: central stall/flush sequencer for the 5-stage pipeline. It sits
// beside decode and resolves, in priority order, data-memory wait, multi-cycle
// mul/div busy, mul/div start, taken-branch redirect and load-use hazards.
// Exactly one hazard class drives the pipeline controls in any cycle.
//
// Parameters:
//    MD_TIMEOUT   max non-frozen cycles spent in MD_BUSY before the watchdog
//                 fires (>= 2)
//    CNT_W        width of the performance counters
//
// Ports:
//    clk     rising-edge clock
//    reset   asynchronous, active-high reset
//    hz      hazard_ctrl_if.slave: hazard inputs in, stall/flush controls,
//            md_timeout and performance counters out
//
// Optional feature: define HAZ_PERF_CNT_EN to build the stall_cycles and
// flush_events counters; without it both outputs are tied to zero and no
// counter flops exist.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input logic          clk,
   input logic          reset,
   hazard_ctrl_if.slave hz
);

   typedef enum logic {RUN, MD_BUSY} state_t;

   localparam int                MDC_W   = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [MDC_W-1:0]  MD_LAST = MDC_W'(MD_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [MDC_W-1:0] md_cnt_q, md_cnt_d;
   logic             md_timeout_q, md_timeout_d;

   logic mem_freeze;
   logic load_use;
   logic pc_stall_c, if_id_stall_c, if_id_flush_c;
   logic id_ex_stall_c, id_ex_flush_c, ex_mem_stall_c, ex_mem_flush_c;

   // A MEM access that has not completed freezes the whole front of the
   // pipeline, including EX, so whatever sits in EX (branch, mul/div start,
   // load) is simply re-evaluated once memory answers.
   assign mem_freeze = hz.mem_req && !hz.dmem_ready;

   // Load in EX whose destination feeds the instruction in ID. x0 is never a
   // real dependency, so ex_rd==0 is excluded.
   assign load_use = hz.ex_MemRead && (hz.ex_rd != 5'd0) &&
                     ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                      (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

   // Priority resolver and next-state logic. Each branch of the if/else chain
   // is one hazard class; the first that matches owns all control outputs for
   // the cycle. In MD_BUSY the result-done cycle releases every stall so the
   // EX/MEM register captures the mul/div result on the same edge that takes
   // the FSM back to RUN. The watchdog fires on the last permitted busy cycle
   // and forces RUN so the pipeline can never hang on a dead unit.
   always_comb begin
      pc_stall_c     = 1'b0;
      if_id_stall_c  = 1'b0;
      if_id_flush_c  = 1'b0;
      id_ex_stall_c  = 1'b0;
      id_ex_flush_c  = 1'b0;
      ex_mem_stall_c = 1'b0;
      ex_mem_flush_c = 1'b0;
      state_d        = state_q;
      md_cnt_d       = md_cnt_q;
      md_timeout_d   = md_timeout_q;

      if (mem_freeze) begin
         pc_stall_c     = 1'b1;
         if_id_stall_c  = 1'b1;
         id_ex_stall_c  = 1'b1;
         ex_mem_stall_c = 1'b1;
      end else if (state_q == MD_BUSY) begin
         if (hz.md_done) begin
            state_d  = RUN;
            md_cnt_d = '0;
         end else begin
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_stall_c  = 1'b1;
            ex_mem_flush_c = 1'b1;
            if (md_cnt_q == MD_LAST) begin
               md_timeout_d = 1'b1;
               state_d      = RUN;
               md_cnt_d     = '0;
            end else begin
               md_cnt_d = md_cnt_q + MDC_W'(1);
            end
         end
      end else if (hz.ex_md_start && !hz.md_done) begin
         pc_stall_c     = 1'b1;
         if_id_stall_c  = 1'b1;
         id_ex_stall_c  = 1'b1;
         ex_mem_flush_c = 1'b1;
         state_d        = MD_BUSY;
         md_cnt_d       = '0;
      end else if (hz.ex_branch_taken) begin
         if_id_flush_c = 1'b1;
         id_ex_flush_c = 1'b1;
      end else if (load_use) begin
         pc_stall_c    = 1'b1;
         if_id_stall_c = 1'b1;
         id_ex_flush_c = 1'b1;
      end
   end

   // FSM state, mul/div watchdog counter and the sticky timeout flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= RUN;
         md_cnt_q     <= '0;
         md_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         md_cnt_q     <= md_cnt_d;
         md_timeout_q <= md_timeout_d;
      end
   end

   // Controls are combinational, so they are gated with reset to guarantee a
   // quiet pipeline for as long as reset is held.
   assign hz.pc_stall     = pc_stall_c     && !reset;
   assign hz.if_id_stall  = if_id_stall_c  && !reset;
   assign hz.if_id_flush  = if_id_flush_c  && !reset;
   assign hz.id_ex_stall  = id_ex_stall_c  && !reset;
   assign hz.id_ex_flush  = id_ex_flush_c  && !reset;
   assign hz.ex_mem_stall = ex_mem_stall_c && !reset;
   assign hz.ex_mem_flush = ex_mem_flush_c && !reset;
   assign hz.md_timeout   = md_timeout_q;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_events_q, flush_events_d;

   // Counters wrap naturally at 2^CNT_W.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (hz.pc_stall) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      if (hz.if_id_flush || hz.id_ex_flush) begin
         flush_events_d = flush_events_q + CNT_W'(1);
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign hz.stall_cycles = stall_cycles_q;
   assign hz.flush_events = flush_events_q;
`else
   assign hz.stall_cycles = {CNT_W{1'b0}};
   assign hz.flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl (MD_TIMEOUT=8). Single-cycle RUN-state
// hazard patterns come from a vector table; the mul/div, timeout, memory-wait
// and reset corner cases are hand-written sequences. Expected results are
// queued when stimulus is driven and compared at the following falling edge.
// Output bit order used throughout:
//    {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
//     ex_mem_stall, ex_mem_flush}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int CNT_W = 32;

`ifdef HAZ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [6:0] O_IDLE = 7'b0000000;
   localparam logic [6:0] O_LU   = 7'b1100100;
   localparam logic [6:0] O_BR   = 7'b0010100;
   localparam logic [6:0] O_FRZ  = 7'b1101010;
   localparam logic [6:0] O_MD   = 7'b1101001;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       memRead;
      logic       br;
      logic       mdStart;
      logic       mdDone;
      logic       memReq;
      logic       dReady;
   } stim_t;

   typedef struct {
      string      name;
      stim_t      s;
      logic [6:0] exp;
   } vec_t;

   typedef struct {
      string      name;
      logic [6:0] outs;
      logic       mdTo;
   } exp_t;

   logic clock;
   logic reset;
   int   checks;
   int   failures;
   exp_t sbq[$];
   vec_t vecs[13];

   hazard_ctrl_if #(.CNT_W(CNT_W)) hzIf ();

   hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(CNT_W)) dut (
      .clk   (clock),
      .reset (reset),
      .hz    (hzIf)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Global time bound so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "[TB] bench did not complete");
   end

   function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic memRead, input logic br, input logic mdStart,
                                input logic mdDone, input logic memReq, input logic dReady);
      stim_t s;
      s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
      s.memRead = memRead; s.br = br; s.mdStart = mdStart; s.mdDone = mdDone;
      s.memReq = memReq; s.dReady = dReady;
      return s;
   endfunction

   function automatic logic [6:0] getOuts();
      return {hzIf.pc_stall, hzIf.if_id_stall, hzIf.if_id_flush, hzIf.id_ex_stall,
              hzIf.id_ex_flush, hzIf.ex_mem_stall, hzIf.ex_mem_flush};
   endfunction

   task automatic drive(input stim_t s);
      hzIf.id_rs1          = s.rs1;
      hzIf.id_rs2          = s.rs2;
      hzIf.id_uses_rs1     = s.u1;
      hzIf.id_uses_rs2     = s.u2;
      hzIf.ex_rd           = s.rd;
      hzIf.ex_MemRead      = s.memRead;
      hzIf.ex_branch_taken = s.br;
      hzIf.ex_md_start     = s.mdStart;
      hzIf.md_done         = s.mdDone;
      hzIf.mem_req         = s.memReq;
      hzIf.dmem_ready      = s.dReady;
   endtask

   task automatic checkValue(input string name, input logic [CNT_W-1:0] act,
                             input logic [CNT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus just after the rising edge and queue what
   // the controller must show during that cycle.
   task automatic applyStimulus(input stim_t s, input string name,
                                input logic [6:0] e, input logic mdTo);
      exp_t x;
      @(posedge clock);
      #1;
      drive(s);
      x.name = name; x.outs = e; x.mdTo = mdTo;
      sbq.push_back(x);
   endtask

   // Compare the oldest queued expectation at the falling edge.
   task automatic checkOutput();
      exp_t x;
      @(negedge clock);
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         x = sbq.pop_front();
         checkValue({x.name, ".outs"}, CNT_W'(getOuts()), CNT_W'(x.outs));
         checkValue({x.name, ".md_timeout"}, CNT_W'(hzIf.md_timeout), CNT_W'(x.mdTo));
      end
   endtask

   task automatic step(input stim_t s, input string name,
                       input logic [6:0] e, input logic mdTo);
      applyStimulus(s, name, e, mdTo);
      checkOutput();
   endtask

   // Reset with a live load-use pattern on the inputs: controls must stay 0.
   task automatic doReset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      drive(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      #1;
      checkValue("reset.outs", CNT_W'(getOuts()), CNT_W'(O_IDLE));
      checkValue("reset.md_timeout", CNT_W'(hzIf.md_timeout), '0);
      @(posedge clock);
      #1;
      checkValue("reset.stall_cycles", hzIf.stall_cycles, '0);
      checkValue("reset.flush_events", hzIf.flush_events, '0);
      drive(mk('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      reset = 1'b0;
   endtask

   initial begin
      stim_t idle;
      stim_t mdStartS;
      stim_t brS;
      int    expStall;
      int    expFlush;

      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      idle     = mk('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      mdStartS = mk('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      brS      = mk('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(idle);

      //            name            rs1    rs2    u1    u2    rd     mRd   br    mdS   mdD   mReq  dRdy    expected
      vecs[0]  = '{"idle",        mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_IDLE};
      vecs[1]  = '{"lu_rs1",      mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_LU};
      vecs[2]  = '{"lu_rs2",      mk(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_LU};
      vecs[3]  = '{"lu_rd0",      mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_IDLE};
      vecs[4]  = '{"lu_unused",   mk(5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_IDLE};
      vecs[5]  = '{"no_load",     mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_IDLE};
      vecs[6]  = '{"rs_differ",   mk(5'd4, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_IDLE};
      vecs[7]  = '{"branch",      mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), O_BR};
      vecs[8]  = '{"branch_lu",   mk(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), O_BR};
      vecs[9]  = '{"freeze",      mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), O_FRZ};
      vecs[10] = '{"freeze_br_lu",mk(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), O_FRZ};
      vecs[11] = '{"mem_ok_br",   mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1), O_BR};
      vecs[12] = '{"md_same_done",mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1), O_IDLE};

      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Table of single-cycle RUN-state patterns.
      doReset();
      expStall = 0;
      expFlush = 0;
      for (int i = 0; i < 13; i++) begin
         step(vecs[i].s, vecs[i].name, vecs[i].exp, 1'b0);
         expStall += int'(vecs[i].exp[6]);
         expFlush += int'(vecs[i].exp[4] | vecs[i].exp[2]);
      end
      step(idle, "table_tail", O_IDLE, 1'b0);
      checkValue("table.stall_cycles", hzIf.stall_cycles, PERF ? CNT_W'(expStall) : '0);
      checkValue("table.flush_events", hzIf.flush_events, PERF ? CNT_W'(expFlush) : '0);

      // Load-use for one cycle, then the load has moved on.
      doReset();
      step(vecs[1].s, "lu_seq0", O_LU, 1'b0);
      step(idle, "lu_seq1", O_IDLE, 1'b0);
      checkValue("lu.stall_cycles", hzIf.stall_cycles, PERF ? CNT_W'(1) : '0);
      checkValue("lu.flush_events", hzIf.flush_events, PERF ? CNT_W'(1) : '0);

      // Branch alone.
      doReset();
      step(brS, "br_seq0", O_BR, 1'b0);
      step(idle, "br_seq1", O_IDLE, 1'b0);
      checkValue("br.stall_cycles", hzIf.stall_cycles, '0);
      checkValue("br.flush_events", hzIf.flush_events, PERF ? CNT_W'(1) : '0);

      // Memory wait holding a taken branch for three cycles.
      doReset();
      for (int i = 0; i < 3; i++) begin
         step(mk('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), "memwait", O_FRZ, 1'b0);
      end
      step(vecs[11].s, "memwait_release", O_BR, 1'b0);
      step(idle, "memwait_tail", O_IDLE, 1'b0);

      // Mul/div: entry, four busy cycles (one with a suppressed branch),
      // md_done on the fifth, then RUN proven by a branch flush.
      doReset();
      step(mdStartS, "md_entry", O_MD, 1'b0);
      step(idle, "md_busy1", O_MD, 1'b0);
      step(brS, "md_busy2_br", O_MD, 1'b0);
      step(idle, "md_busy3", O_MD, 1'b0);
      step(idle, "md_busy4", O_MD, 1'b0);
      step(mk('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), "md_done", O_IDLE, 1'b0);
      step(brS, "md_after_br", O_BR, 1'b0);
      step(idle, "md_after_idle", O_IDLE, 1'b0);

      // Watchdog with MD_TIMEOUT=8: eight non-frozen busy cycles, one frozen
      // cycle in the middle that must not advance the counter.
      doReset();
      step(mdStartS, "to_entry", O_MD, 1'b0);
      for (int i = 0; i < 3; i++) step(idle, "to_busy_a", O_MD, 1'b0);
      step(mk('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "to_freeze", O_FRZ, 1'b0);
      for (int i = 0; i < 5; i++) step(idle, "to_busy_b", O_MD, 1'b0);
      step(idle, "to_fired", O_IDLE, 1'b1);
      step(brS, "to_run_br", O_BR, 1'b1);
      for (int i = 0; i < 3; i++) step(idle, "to_sticky", O_IDLE, 1'b1);
      doReset();
      checkValue("to_cleared", CNT_W'(hzIf.md_timeout), '0);

      // Asynchronous reset in the middle of an MD_BUSY cycle.
      step(mdStartS, "ar_entry", O_MD, 1'b0);
      step(idle, "ar_busy", O_MD, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkValue("ar.outs", CNT_W'(getOuts()), CNT_W'(O_IDLE));
      checkValue("ar.md_timeout", CNT_W'(hzIf.md_timeout), '0);
      checkValue("ar.stall_cycles", hzIf.stall_cycles, '0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      step(brS, "ar_run_br", O_BR, 1'b0);

      checkValue("sb_drained", CNT_W'(sbq.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the stall/flush inputs of if_id_reg, id_ex_reg and ex_mem_reg, plus the PC enable.
- Resolves four hazard classes: data-memory wait, multi-cycle mul/div busy, taken-branch redirect, load-use.
- Sits beside the decode stage; registered state tracks multi-cycle freezes.

Parameters:
MD_TIMEOUT, 64, max cycles in MD_BUSY before md_timeout asserts (>=2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd in EX (from id_ex_reg)
ex_MemRead  in  1  EX instruction is a load
ex_branch_taken  in  1  branch/jump in EX resolved taken
ex_md_start  in  1  EX holds a mul/div op needing multi-cycle unit
md_done  in  1  mul/div result valid (one-cycle pulse)
mem_req  in  1  MEM stage issuing load/store
dmem_ready  in  1  data memory completes access this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  clear ID/EX (bubble)
ex_mem_stall  out  1  hold EX/MEM
ex_mem_flush  out  1  insert bubble into EX/MEM
md_timeout  out  1  sticky watchdog error
stall_cycles  out  CNT_W  perf counter (see Optional Feature)
flush_events  out  CNT_W  perf counter (see Optional Feature)

Behaviour:
- State register: RUN, MD_BUSY. Outputs are combinational from state and current inputs; state, timeout counter and md_timeout are registered.
- Reset (async, active-high): state=RUN, md counter=0, md_timeout=0, perf counters=0; all outputs 0 while reset is high.
- Priority, highest first. Exactly one class is applied per cycle.
- 1. MEM freeze: mem_req && !dmem_ready, in any state.
  - Assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall.
  - All flushes forced 0.
  - State unchanged; md counter holds.
  - Branch is not lost: EX is frozen, so ex_branch_taken re-evaluates on release.
- 2. MD_BUSY:
  - Assert pc_stall, if_id_stall, id_ex_stall, ex_mem_flush.
  - Branch flush is suppressed.
  - md counter increments each non-frozen cycle.
  - md_done → RUN next cycle; stalls deassert in that same cycle, so EX/MEM captures the result on that edge.
  - md counter reaching MD_TIMEOUT-1 without md_done: set md_timeout (sticky until reset), force RUN.
- 3. RUN && ex_md_start:
  - Enter MD_BUSY next cycle, counter=0.
  - This cycle: stall PC, IF/ID and ID/EX; ex_mem_flush=1.
  - md_done in the same cycle as ex_md_start: stay RUN, no stall.
- 4. RUN && ex_branch_taken:
  - if_id_flush=1, id_ex_flush=1, no stalls.
  - Overrides a simultaneous load-use (the dependent instruction is discarded).
- 5. RUN, load-use: ex_MemRead && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
  - pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly one cycle.
  - Next cycle the load has moved to MEM, so no re-detection.
- Never assert stall and flush on the same register in the same cycle.
- ex_rd==0 never causes a hazard.
- Reset mid-MD_BUSY: immediate RUN, outputs 0.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every cycle with pc_stall=1.
  - flush_events increments on every cycle with if_id_flush or id_ex_flush =1.
  - Both wrap at 2^CNT_W and reset to 0.
- Undefined: both outputs tied to 0, no counter flops.

Test Plan:
- Load-use: ex_MemRead=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle pc_stall=1, if_id_stall=1, id_ex_flush=1; next cycle (ex_MemRead=0) all 0. Repeat with ex_rd=0 → no stall.
- Branch vs load-use same cycle: ex_branch_taken=1 plus the load-use condition → if_id_flush=1, id_ex_flush=1, pc_stall=0.
- Mem wait: mem_req=1, dmem_ready=0 for 3 cycles with ex_branch_taken=1 → four stall outputs high, flushes 0 for 3 cycles; on cycle 4 dmem_ready=1 → flushes asserted, stalls 0.
- Mul/div: ex_md_start pulse, md_done on 5th cycle after entry → stalls plus ex_mem_flush high through the done cycle's entry; RUN and stalls 0 in the done cycle; md_timeout=0.
- Timeout: MD_TIMEOUT=8, no md_done → md_timeout=1 after 8 cycles, state RUN, stays 1 until reset.
- Async reset asserted in MD_BUSY mid-cycle → all outputs 0 immediately. With HAZ_PERF_CNT_EN, the load-use scenario yields stall_cycles=1 and the branch scenario flush_events=1.
